// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC date/time commit blocks.
package rtc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VALIDATE,
        S_ALE_HI,
        S_ALE_LO,
        S_WR_LO,
        S_WR_HI,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] RTC_ADDR_DAY  = 8'h24;
    localparam logic [7:0] RTC_ADDR_MES  = 8'h25;
    localparam logic [7:0] RTC_ADDR_YEAR = 8'h26;

    localparam logic [7:0] MAXDAY_28 = 8'd28;
    localparam logic [7:0] MAXDAY_29 = 8'd29;
    localparam logic [7:0] MAXDAY_30 = 8'd30;
    localparam logic [7:0] MAXDAY_31 = 8'd31;

    function automatic logic [7:0] bcd2bin(input logic [7:0] b);
        return ({4'd0, b[7:4]} * 8'd10) + {4'd0, b[3:0]};
    endfunction

endpackage

// File: rtl/bcd_date_check.sv
// Combinational calendar check of a BCD day/month/year triple.
module bcd_date_check
    import rtc_pkg::*;
(
    input  logic [7:0] dia_i,
    input  logic [7:0] mes_i,
    input  logic [7:0] year_i,
    output logic       valid_o
);

    logic [7:0] d_bin, m_bin, y_bin, maxday;
    logic       nib_ok, leap;

    always_comb begin
        d_bin  = bcd2bin(dia_i);
        m_bin  = bcd2bin(mes_i);
        y_bin  = bcd2bin(year_i);
        nib_ok = (dia_i[7:4] <= 4'd9) && (dia_i[3:0] <= 4'd9) &&
                 (mes_i[7:4] <= 4'd9) && (mes_i[3:0] <= 4'd9) &&
                 (year_i[7:4] <= 4'd9) && (year_i[3:0] <= 4'd9);
        // mod 4 of the binary year is its low two bits; 00 is leap
        leap   = (y_bin[1:0] == 2'b00);
        case (m_bin)
            8'd4, 8'd6, 8'd9, 8'd11: maxday = MAXDAY_30;
            8'd2:                    maxday = leap ? MAXDAY_29 : MAXDAY_28;
            default:                 maxday = MAXDAY_31;
        endcase
        valid_o = nib_ok &&
                  (m_bin >= 8'd1) && (m_bin <= 8'd12) &&
                  (d_bin >= 8'd1) && (d_bin <= maxday);
    end

endmodule

// File: rtl/rtc_date_writer.sv
// Validates a latched BCD date and writes day, month, year into the RTC
// over its multiplexed AD bus. All outputs are registered from the state.
module rtc_date_writer
    import rtc_pkg::*;
#(
    parameter logic [7:0] ADDR_DAY     = RTC_ADDR_DAY,
    parameter logic [7:0] ADDR_MES     = RTC_ADDR_MES,
    parameter logic [7:0] ADDR_YEAR    = RTC_ADDR_YEAR,
    parameter int         PHASE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       commit,
    input  logic [7:0] dia,
    input  logic [7:0] mes,
    input  logic [7:0] year,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       cs_n,
    output logic       ale,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] ad_out,
    output logic       ad_oe
);

    localparam logic [3:0] PLAST = 4'(PHASE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] dia_q, dia_d, mes_q, mes_d, year_q, year_d;
    logic       valid, phase_end, in_phase;
    logic [7:0] addr_sel, data_sel;

    logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic       cs_n_q, cs_n_d, ale_q, ale_d, wr_n_q, wr_n_d, ad_oe_q, ad_oe_d;
    logic [7:0] ad_q, ad_d;

    bcd_date_check u_check (
        .dia_i   (dia_q),
        .mes_i   (mes_q),
        .year_i  (year_q),
        .valid_o (valid)
    );

    always_comb begin
        case (idx_q)
            2'd0:    begin addr_sel = ADDR_DAY;  data_sel = dia_q;  end
            2'd1:    begin addr_sel = ADDR_MES;  data_sel = mes_q;  end
            default: begin addr_sel = ADDR_YEAR; data_sel = year_q; end
        endcase
    end

    assign phase_end = (cnt_q == PLAST);
    assign in_phase  = (state_q == S_ALE_HI) || (state_q == S_ALE_LO) ||
                       (state_q == S_WR_LO)  || (state_q == S_WR_HI);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dia_d   = dia_q;
        mes_d   = mes_q;
        year_d  = year_q;
        case (state_q)
            S_IDLE: begin
                // busy_q still reads 1 in the DONE/ERR output cycle
                if (commit && !busy_q) begin
                    dia_d   = dia;
                    mes_d   = mes;
                    year_d  = year;
                    state_d = S_VALIDATE;
                end
            end
            S_VALIDATE: begin
                idx_d   = 2'd0;
                state_d = valid ? S_ALE_HI : S_ERR;
            end
            S_ALE_HI: if (phase_end) state_d = S_ALE_LO;
            S_ALE_LO: if (phase_end) state_d = S_WR_LO;
            S_WR_LO:  if (phase_end) state_d = S_WR_HI;
            S_WR_HI: begin
                if (phase_end) begin
                    if (idx_q < 2'd2) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_ALE_HI;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        cnt_d = (state_d != state_q || !in_phase) ? 4'd0 : cnt_q + 4'd1;
    end

    always_comb begin
        busy_d  = (state_q != S_IDLE);
        done_d  = (state_q == S_DONE);
        err_d   = (state_q == S_ERR);
        cs_n_d  = 1'b1;
        ale_d   = 1'b0;
        wr_n_d  = 1'b1;
        ad_oe_d = 1'b0;
        ad_d    = 8'h00;
        case (state_q)
            S_ALE_HI: begin cs_n_d = 1'b0; ale_d = 1'b1; ad_oe_d = 1'b1; ad_d = addr_sel; end
            S_ALE_LO: begin cs_n_d = 1'b0; ad_oe_d = 1'b1; ad_d = addr_sel; end
            S_WR_LO:  begin cs_n_d = 1'b0; wr_n_d = 1'b0; ad_oe_d = 1'b1; ad_d = data_sel; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 2'd0;
            dia_q   <= 8'h00;
            mes_q   <= 8'h00;
            year_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            ale_q   <= 1'b0;
            wr_n_q  <= 1'b1;
            ad_oe_q <= 1'b0;
            ad_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dia_q   <= dia_d;
            mes_q   <= mes_d;
            year_q  <= year_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cs_n_q  <= cs_n_d;
            ale_q   <= ale_d;
            wr_n_q  <= wr_n_d;
            ad_oe_q <= ad_oe_d;
            ad_q    <= ad_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign cs_n   = cs_n_q;
    assign ale    = ale_q;
    assign wr_n   = wr_n_q;
    assign rd_n   = 1'b1;
    assign ad_out = ad_q;
    assign ad_oe  = ad_oe_q;

endmodule

// File: doc/rtc_date_writer.md
Name: rtc_date_writer

Overview:
- Commits an edited BCD date (day, month, year) from the date-editing front end into the external RTC.
- Uses the RTC's multiplexed address/data parallel bus.
- Calendar-validates the latched date, then issues three register write cycles: day, month, year.
- Reports completion or rejection to the top-level control FSM.

Parameters:
- ADDR_DAY, 8'h24, RTC register address for day of month.
- ADDR_MES, 8'h25, RTC register address for month.
- ADDR_YEAR, 8'h26, RTC register address for year.
- PHASE_CYCLES, 2, clocks per bus phase; legal values 1..15.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- commit  in  1  one-cycle request to write the date inputs.
- dia  in  8  BCD day, [7:4] tens, [3:0] units.
- mes  in  8  BCD month.
- year  in  8  BCD year, 00..99.
- busy  out  1  high while the FSM is not in IDLE.
- done  out  1  one-cycle pulse: all three writes finished.
- err  out  1  one-cycle pulse: date rejected, no bus activity.
- cs_n  out  1  RTC chip select, active low.
- ale  out  1  address latch enable, active high.
- wr_n  out  1  write strobe, active low.
- rd_n  out  1  read strobe; held 1 permanently.
- ad_out  out  8  multiplexed address/data value.
- ad_oe  out  1  drive enable for the AD tristate at top level.

Behaviour:
- Reset (reset=0 at an edge):
  - FSM goes to IDLE; latches clear to 0.
  - busy=0, done=0, err=0, cs_n=1, ale=0, wr_n=1, rd_n=1, ad_out=0, ad_oe=0.
  - Applies mid-transaction; the bus is released on the next edge; no partial-write recovery.
- States and transitions:
  - IDLE: commit=1 latches dia/mes/year and goes to VALIDATE.
  - VALIDATE: 1 cycle; goes to ERR if the date is invalid, else to ALE_HI with reg index 0.
  - ALE_HI (P cycles): cs_n=0, ale=1, ad_oe=1, ad_out=address[index].
  - ALE_LO (P cycles): ale=0, ad_out holds the address.
  - WR_LO (P cycles): wr_n=0, ad_out=data[index].
  - WR_HI (P cycles): wr_n=1, cs_n=1, ad_oe=0, ad_out=0.
  - After WR_HI: if index<2, increment index and return to ALE_HI; else go to DONE.
  - DONE: 1 cycle; done=1; then IDLE.
  - ERR: 1 cycle; err=1; then IDLE.
- Register order: index 0 = day/ADDR_DAY, 1 = month/ADDR_MES, 2 = year/ADDR_YEAR.
- Phase counter: 4-bit; counts 0..P-1 and resets on each state change.
- Latency, relative to the edge that samples commit:
  - done is high in the cycle starting 2+12*P edges later (26 for P=2).
  - err is high in the cycle starting 2 edges later.
- busy is high from the cycle after commit through the DONE/ERR cycle inclusive.
- commit while busy=1 is ignored; it is not queued.
- Inputs are sampled only at the commit edge; later changes have no effect on the transaction.
- Validation (all must hold, otherwise ERR):
  - Every nibble is ≤9.
  - mes is 01..12.
  - dia is 01..maxday.
    - maxday = 31 for months 01, 03, 05, 07, 08, 10, 12.
    - maxday = 30 for months 04, 06, 09, 11.
    - Month 02: 29 if the year is leap, else 28.
  - Leap year: binary value (10*tens+units) mod 4 == 0; year 00 counts as leap.
  - Comparisons are done on BCD directly or on converted binary; the result must be identical.
- Outputs are registered, so bus signals are glitch-free.

Decomposition:
- Shared package rtc_pkg:
  - FSM state encoding (IDLE, VALIDATE, ALE_HI, ALE_LO, WR_LO, WR_HI, DONE, ERR).
  - Default RTC register address constants.
  - maxday constants 28/29/30/31.
- One natural sub-module: bcd_date_check.
  - Purely combinational: dia/mes/year in, valid out.
  - Instantiated once and reused by the time-commit block later.

Test Plan:
- Valid date, P=2: commit with dia=8'h15, mes=8'h07, year=8'h16.
  - Three write cycles, with ad_out sampled on ale fall / wr_n rise as (24,15), (25,07), (26,16).
  - done pulse exactly 26 cycles after commit; busy low the following cycle.
- Leap boundary: 29/02/24 -> done, with writes 29, 02, 24; 29/02/23 -> err 2 cycles after commit, cs_n stays 1 throughout.
- Month/day limits: 31/04/16 -> err; 30/04/16 -> done; 00/01/16 -> err; 01/13/16 -> err.
- Illegal BCD: dia=8'h1A -> err; year=8'h9F -> err; no bus activity in either case.
- Commit while busy: second commit with different data 5 cycles into a transaction is ignored; only the first date is written; exactly one done pulse.
- Reset mid-op: reset=0 during the second WR_LO.
  - Next edge shows cs_n=1, wr_n=1, ad_oe=0, busy=0, and no done pulse.
  - A new commit after release writes normally.
